// File: rtl/vrf_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : vrf_stream_if
//  Brief    : Wide write/read ports and element-stream handshake of vrf_stream.
//  Revision : 1.0
// ============================================================================
interface vrf_stream_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int MAXVL = 16
);
    localparam int AW = $clog2(NREG);
    localparam int VW = $clog2(MAXVL) + 1;

    logic                  we;
    logic [AW-1:0]         wa;
    logic [VW-1:0]         wvl;
    logic [MAXVL-1:0]      wmask;
    logic [XLEN*MAXVL-1:0] wd;
    logic [AW-1:0]         ra;
    logic [XLEN*MAXVL-1:0] rd;
    logic                  s_start;
    logic [AW-1:0]         s_base;
    logic [VW-1:0]         s_vl;
    logic                  s_valid;
    logic                  s_ready;
    logic [XLEN-1:0]       s_data;
    logic [VW-1:0]         s_idx;
    logic                  s_last;
    logic                  s_busy;

    modport master (
        output we, wa, wvl, wmask, wd, ra, s_start, s_base, s_vl, s_ready,
        input  rd, s_valid, s_data, s_idx, s_last, s_busy
    );

    modport slave (
        input  we, wa, wvl, wmask, wd, ra, s_start, s_base, s_vl, s_ready,
        output rd, s_valid, s_data, s_idx, s_last, s_busy
    );
endinterface
`default_nettype wire

// File: rtl/vrf_stream.sv
`default_nettype none
// ============================================================================
//  Module   : vrf_stream
//  Brief    : Vector register file with masked wide write, write-first wide
//             read and a one-element-per-cycle streaming port.
//  Revision : 1.0
// ============================================================================
module vrf_stream #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int MAXVL = 16
) (
    input  logic        clk,
    input  logic        rst,
    vrf_stream_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int VW = $clog2(MAXVL) + 1;
    localparam logic [VW-1:0] C_MAXVL = VW'(MAXVL);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [XLEN-1:0]       rf_q [NREG];
    logic [XLEN-1:0]       rf_d [NREG];
    logic [XLEN*MAXVL-1:0] rd_q, rd_d;
    state_t                state_q, state_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [VW-1:0]         cnt_q, cnt_d;
    logic [VW-1:0]         idx_q, idx_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [VW-1:0]         w_wvl_eff, w_svl_eff;
    logic [MAXVL-1:0]      w_lane_we;

    assign w_wvl_eff = (bus.wvl  > C_MAXVL) ? C_MAXVL : bus.wvl;
    assign w_svl_eff = (bus.s_vl > C_MAXVL) ? C_MAXVL : bus.s_vl;

    // rf_d is the post-write register image; every read below taps it so
    // reads and stream loads see a same-edge write (write-first).
    always_comb begin
        w_lane_we = '0;
        rf_d      = rf_q;
        for (int j = 0; j < MAXVL; j++) begin
            w_lane_we[j] = bus.we && bus.wmask[j] && (VW'(j) < w_wvl_eff);
            if (w_lane_we[j]) begin
                rf_d[bus.wa + AW'(j)] = bus.wd[XLEN*j +: XLEN];
            end
        end
        rd_d = '0;
        for (int j = 0; j < MAXVL; j++) begin
            rd_d[XLEN*j +: XLEN] = rf_d[bus.ra + AW'(j)];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.s_start && (w_svl_eff != '0)) begin
                    state_d = ST_RUN;
                    ptr_d   = bus.s_base;
                    cnt_d   = w_svl_eff;
                    idx_d   = '0;
                    data_d  = rf_d[bus.s_base];
                    valid_d = 1'b1;
                    last_d  = (w_svl_eff == VW'(1));
                end
            end
            ST_RUN: begin
                if (bus.s_ready) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = '0;
                    end else begin
                        ptr_d  = ptr_q + AW'(1);
                        idx_d  = idx_q + VW'(1);
                        data_d = rf_d[ptr_q + AW'(1)];
                        // next element is the last one when its index is cnt-1
                        last_d = (({1'b0, idx_q} + (VW+1)'(2)) == {1'b0, cnt_q});
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            rd_q    <= '0;
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
            rd_q    <= rd_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.rd      = rd_q;
    assign bus.s_valid = valid_q;
    assign bus.s_busy  = valid_q;
    assign bus.s_data  = data_q;
    assign bus.s_idx   = idx_q;
    assign bus.s_last  = last_q;
endmodule
`default_nettype wire
